mem_wb_pipe: RTL

- Producer end of the operand-forwarding interface.
- Implements the EX/MEM and MEM/WB pipeline registers, the data-memory handshake for loads/stores, and the register-file write port.
- Drives the rd/reg_write/data pairs the forwarding unit consumes, and stalls the pipeline while a memory access is outstanding.

---
 rtl/mem_wb_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with data-memory handshake, stall
// generation and register-file write port. Define MEM_TIMEOUT_EN to enable the wait-timeout abort.
module mem_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              flush_ex,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              pipe_stall,
    output logic [REG_AW-1:0] rd_EXMEM,
    output logic              reg_write_EXMEM,
    output logic [DATA_W-1:0] fwd_data_EXMEM,
    output logic [REG_AW-1:0] rd_MEMWB,
    output logic              reg_write_MEMWB,
    output logic [DATA_W-1:0] fwd_data_MEMWB,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_err
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t state;

    // EX/MEM register fields
    logic              exm_valid;
    logic [REG_AW-1:0] exm_rd;
    logic              exm_reg_write;
    logic              exm_mem_read;
    logic              exm_mem_write;
    logic [DATA_W-1:0] exm_alu;
    logic [DATA_W-1:0] exm_store;

    // MEM/WB register fields
    logic [REG_AW-1:0] mwb_rd;
    logic              mwb_reg_write;
    logic [DATA_W-1:0] mwb_data;

    logic memop;
    logic abort;

    assign memop = exm_valid & (exm_mem_read | exm_mem_write);

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    logic [3:0] wait_cnt;
    logic       err_q;

    assign abort   = (state == S_WAIT) && !dmem_ack && (wait_cnt == TIMEOUT_CNT);
    assign mem_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_RUN && memop && !dmem_ack)
                wait_cnt <= '0;
            else if (state == S_WAIT && !dmem_ack)
                wait_cnt <= wait_cnt + 4'd1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // An aborted access releases the stall so the pipeline can move on.
    assign pipe_stall = memop & ~dmem_ack & ~abort;

    assign dmem_req   = memop & ~abort;
    assign dmem_we    = exm_valid & exm_mem_write;
    assign dmem_addr  = exm_alu;
    assign dmem_wdata = exm_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            case (state)
                S_RUN:   if (memop && !dmem_ack) state <= S_WAIT;
                S_WAIT:  if (dmem_ack || abort)  state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end

    // NOTE: every register here uses <= so all stages sample the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_valid     <= 1'b0;
            exm_rd        <= '0;
            exm_reg_write <= 1'b0;
            exm_mem_read  <= 1'b0;
            exm_mem_write <= 1'b0;
            exm_alu       <= '0;
            exm_store     <= '0;
        end else if (!pipe_stall) begin
            if (ex_valid && !flush_ex) begin
                exm_valid     <= 1'b1;
                exm_rd        <= ex_rd;
                // A store never writes the register file, and never reads memory.
                exm_reg_write <= ex_reg_write & ~ex_mem_write;
                exm_mem_read  <= ex_mem_read & ~ex_mem_write;
                exm_mem_write <= ex_mem_write;
                exm_alu       <= ex_alu_result;
                exm_store     <= ex_store_data;
            end else begin
                exm_valid     <= 1'b0;
                exm_rd        <= '0;
                exm_reg_write <= 1'b0;
                exm_mem_read  <= 1'b0;
                exm_mem_write <= 1'b0;
                exm_alu       <= '0;
                exm_store     <= '0;
            end
        end
    end

    // Bubbles while stalled so each instruction reaches writeback exactly once.
    always_ff @(posedge clk) begin
        if (rst || pipe_stall || abort) begin
            mwb_rd        <= '0;
            mwb_reg_write <= 1'b0;
            mwb_data      <= '0;
        end else begin
            mwb_rd        <= exm_rd;
            mwb_reg_write <= exm_valid & exm_reg_write;
            mwb_data      <= (exm_valid && exm_mem_read) ? dmem_rdata : exm_alu;
        end
    end

    assign rd_EXMEM        = exm_rd;
    assign reg_write_EXMEM = exm_valid & exm_reg_write;
    assign fwd_data_EXMEM  = exm_alu;

    assign rd_MEMWB        = mwb_rd;
    assign reg_write_MEMWB = mwb_reg_write;
    assign fwd_data_MEMWB  = mwb_data;

    assign rf_we    = mwb_reg_write & (mwb_rd != '0);
    assign rf_waddr = mwb_rd;
    assign rf_wdata = mwb_data;

endmodule
